// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with sticky overflow/underflow flags and flush.
// Define PARAM_FIFO_FWFT_EN for first-word fall-through reads; default is a registered read.
module param_fifo #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 1,
  parameter int unsigned AE_LEVEL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            pop_data,
  output logic                         pop_valid,
  input  logic                         flush,
  input  logic                         clr_err,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         almost_empty,
  output logic                         overflow,
  output logic                         underflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_acc_c;
  logic              pop_acc_c;
  logic              ovf_set_c;
  logic              udf_set_c;

  // Pointers wrap at DEPTH-1 so non power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full         = (count == CNT_W'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CNT_W'(AF_LEVEL));
  assign almost_empty = (count <= CNT_W'(AE_LEVEL));

  assign push_acc_c = push && !full  && !flush;
  assign pop_acc_c  = pop  && !empty && !flush;
  assign ovf_set_c  = push && full   && !flush;
  assign udf_set_c  = pop  && empty  && !flush;

  // Occupancy and pointer state; flush zeroes everything on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_acc_c) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_acc_c)  rd_ptr <= ptr_inc(rd_ptr);
      if (push_acc_c && !pop_acc_c)      count <= count + CNT_W'(1);
      else if (pop_acc_c && !push_acc_c) count <= count - CNT_W'(1);
    end
  end

  // Storage is not reset; stale contents are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push_acc_c) mem[wr_ptr] <= push_data;
  end

  // Sticky error flags: a new error wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set_c)    overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (udf_set_c)    underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  // Head entry shown directly; forced to zero while empty to keep the bus defined.
  assign pop_valid = !empty;
  assign pop_data  = empty ? '0 : mem[rd_ptr];
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      pop_valid <= pop_acc_c;
      if (pop_acc_c) pop_data <= mem[rd_ptr];
    end
  end
`endif

endmodule

// File: tb/tb_param_fifo.sv
// Directed scoreboard bench for param_fifo (DEPTH=4); read-mode expectations follow PARAM_FIFO_FWFT_EN.
module tb_param_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [7:0] push_data;
  logic       pop;
  logic [7:0] pop_data;
  logic       pop_valid;
  logic       flush;
  logic       clr_err;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;

  logic [7:0] sb [$];
  int         m_count;
  logic       m_ovf;
  logic       m_udf;
  logic [7:0] m_last;

  param_fifo #(.DATA_W(8), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
    .pop_data(pop_data), .pop_valid(pop_valid), .flush(flush), .clr_err(clr_err),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_last  = 8'h00;
  endtask

  task automatic check_status();
    chk("count",        32'(count),   32'(m_count));
    chk("full",         full,         m_count == 4);
    chk("empty",        empty,        m_count == 0);
    chk("almost_full",  almost_full,  m_count >= 3);
    chk("almost_empty", almost_empty, m_count <= 1);
    chk("overflow",     overflow,     m_ovf);
    chk("underflow",    underflow,    m_udf);
  endtask

  // One clock of stimulus; entered and left at 1 time unit after a rising edge.
  task automatic cycle(input logic p, input logic [7:0] d, input logic q,
                       input logic f, input logic c);
    logic pa, qa, os, us;
    logic [7:0] exp_d;
    push = p; push_data = d; pop = q; flush = f; clr_err = c;
    pa = p && (m_count < 4) && !f;
    qa = q && (m_count > 0) && !f;
    os = p && (m_count == 4) && !f;
    us = q && (m_count == 0) && !f;
    #3;
`ifdef PARAM_FIFO_FWFT_EN
    chk("pop_valid_fwft", pop_valid, m_count != 0);
    if (qa) begin
      exp_d = sb.pop_front();
      chk("pop_data_fwft", 32'(pop_data), 32'(exp_d));
    end
`endif
    if (pa) sb.push_back(d);
    @(posedge clk);
    #1;
`ifndef PARAM_FIFO_FWFT_EN
    if (qa) m_last = sb.pop_front();
    chk("pop_valid_reg", pop_valid, qa);
    chk("pop_data_reg",  32'(pop_data), 32'(m_last));
`endif
    if (f) begin
      sb.delete();
      m_count = 0;
    end else if (pa && !qa) m_count = m_count + 1;
    else if (qa && !pa)     m_count = m_count - 1;
    if (os)     m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
    if (us)     m_udf = 1'b1;
    else if (c) m_udf = 1'b0;
    check_status();
    push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; push_data = 8'h00; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_status();
    chk("rst_pop_valid", pop_valid, 1'b0);
    chk("rst_pop_data",  32'(pop_data), 32'h0);
    rst = 1'b0;

    // Fill to full, then overflow, then drain in order
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    chk("fill_af_after_3", almost_full, 1'b1);
    cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    chk("fill_full_after_4", full, 1'b1);
    chk("fill_count_4", 32'(count), 32'd4);
    cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    chk("fill_overflow", overflow, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("drain_empty", empty, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Underflow and clear
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("udf_set", underflow, 1'b1);
    chk("udf_count", 32'(count), 32'd0);
    chk("udf_pop_valid", pop_valid, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("udf_cleared", underflow, 1'b0);

    // Wrap with simultaneous push/pop at occupancy 2
    cycle(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h81, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 8'(8'h82 + i), 1'b1, 1'b0, 1'b0);
      chk("wrap_count_2", 32'(count), 32'd2);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Push and pop together while full
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
    chk("fullpp_count_3", 32'(count), 32'd3);
    chk("fullpp_overflow", overflow, 1'b1);

    // Flush with a concurrent push
    cycle(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", empty, 1'b1);
    chk("flush_ovf_kept", overflow, 1'b1);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Reset mid-operation with two entries stored
    cycle(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    model_reset();
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_pop_valid", pop_valid, 1'b0);
    chk("midrst_pop_data", 32'(pop_data), 32'h0);
    chk("midrst_overflow", overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    chk("post_rst_count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
